// File: rtl/mem_access_unit.sv
// Memory access stage: issues one bus transaction per aligned load/store,
// stalls the pipeline until the bus acks or times out, and loads the MEM/WB
// register. Also resolves branch/jump redirection for the fetch stage.
//
// state | meaning
// IDLE  | no bus transaction; pass-through ops retire, aligned accesses start
// BUSY  | mem_req held high, counting cycles until mem_ack or timeout
// DONE  | access finished; MEM/WB loads the result on the next edge
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        ALUzero_in,
  input  logic [4:0]  regRd_in,
  input  logic [31:0] memadd_in,
  input  logic [31:0] Wrdata_in,
  input  logic [31:0] branchpc_in,
  input  logic [31:0] jumpaddr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        align_err,
  output logic        bus_err,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [4:0]  regRd_out,
  output logic [31:0] readdata_out,
  output logic [31:0] aluresult_out
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          failed;
  logic [31:0]   hold_rdata;
  logic          op, mis, is_write;
  logic          start, ack_hit, tmo_hit;

  assign op       = MemRead_in | MemWrite_in;
  assign mis      = op & (memadd_in[1:0] != 2'b00);
  assign is_write = MemWrite_in;

  // Next-state and stall decode; ack wins over a same-cycle timeout
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start     = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (op && !mis) begin
          stall     = 1'b1;
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus request, cycle counter, error pulses and read-data holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      bus_err    <= 1'b0;
      align_err  <= 1'b0;
      failed     <= 1'b0;
      hold_rdata <= '0;
    end else begin
      bus_err   <= tmo_hit;
      align_err <= (state == IDLE) && mis;
      if (start) begin
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= is_write;
        mem_addr  <= memadd_in;
        mem_wdata <= Wrdata_in;
        failed    <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (ack_hit) begin
          mem_req    <= 1'b0;
          hold_rdata <= mem_rdata;
        end else if (tmo_hit) begin
          mem_req <= 1'b0;
          failed  <= 1'b1;
        end
      end
    end
  end

  // MEM/WB register: bubble while stalled, otherwise load from the stage inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      regRd_out     <= '0;
      readdata_out  <= '0;
      aluresult_out <= '0;
    end else if (stall) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
    end else begin
      MemtoReg_out  <= MemtoReg_in;
      regRd_out     <= regRd_in;
      aluresult_out <= memadd_in;
      if (state == DONE) begin
        RegWrite_out <= RegWrite_in & ~failed;
        readdata_out <= hold_rdata;
      end else begin
        RegWrite_out <= RegWrite_in & ~mis;
      end
    end
  end

  assign pcsrc     = ~stall & (Jump_in | (Branch_in & ALUzero_in));
  assign pc_target = Jump_in ? jumpaddr_in : branchpc_in;
  assign flush     = pcsrc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit. Each instruction is
// described by its fields and an ack delay; the expected stall length, bus
// activity and MEM/WB contents are derived from the access rules directly.
module tb_mem_access_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
  logic        Branch_in, Jump_in, ALUzero_in;
  logic [4:0]  regRd_in;
  logic [31:0] memadd_in, Wrdata_in, branchpc_in, jumpaddr_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, pcsrc, flush, align_err, bus_err;
  logic [31:0] pc_target;
  logic        RegWrite_out, MemtoReg_out;
  logic [4:0]  regRd_out;
  logic [31:0] readdata_out, aluresult_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rdata;
  logic        g_br, g_jp, g_z;
  logic [31:0] g_bpc, g_jaddr;
  int          last_stall_cycles;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .Branch_in(Branch_in), .Jump_in(Jump_in), .ALUzero_in(ALUzero_in),
    .regRd_in(regRd_in), .memadd_in(memadd_in), .Wrdata_in(Wrdata_in),
    .branchpc_in(branchpc_in), .jumpaddr_in(jumpaddr_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .pcsrc(pcsrc), .pc_target(pc_target), .flush(flush),
    .align_err(align_err), .bus_err(bus_err),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .regRd_out(regRd_out), .readdata_out(readdata_out),
    .aluresult_out(aluresult_out)
  );

  always #5 clk = ~clk;

  task automatic drive_nop();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; MemtoReg_in = 1'b0;
    RegWrite_in = 1'b0; Branch_in = 1'b0; Jump_in = 1'b0; ALUzero_in = 1'b0;
    regRd_in = '0; memadd_in = '0; Wrdata_in = '0;
    branchpc_in = '0; jumpaddr_in = '0;
  endtask

  // Runs one instruction from posedge+1 through its retiring edge, then one nop.
  task automatic run_instr(input logic rd, input logic wr, input logic rw,
                           input logic mtr, input logic [4:0] ridx,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata_v);
    logic op, mis, tmo, exp_stall, exp_pcsrc;
    logic [31:0] exp_target;
    int busy, stall_n, cyc, req_seen, berr_seen, stall_seen;
    bit done;
    op  = rd | wr;
    mis = op && (addr[1:0] != 2'b00);
    tmo = 1'b0;
    busy = 0;
    if (op && !mis) begin
      busy = (ack_at <= TMO) ? ack_at : TMO;
      tmo  = (ack_at > TMO);
    end
    stall_n = (op && !mis) ? busy + 1 : 0;
    exp_target = g_jp ? g_jaddr : g_bpc;

    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemtoReg_in = mtr;
    regRd_in = ridx; memadd_in = addr; Wrdata_in = wdata;
    Branch_in = g_br; Jump_in = g_jp; ALUzero_in = g_z;
    branchpc_in = g_bpc; jumpaddr_in = g_jaddr;

    cyc = 0; req_seen = 0; berr_seen = 0; stall_seen = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req) begin
        req_seen++;
        mem_ack   = (req_seen == ack_at);
        mem_rdata = mem_ack ? rdata_v : $urandom;
        if (req_seen == 1) begin
          checks++;
          if (mem_we !== wr || mem_addr !== addr || (wr && mem_wdata !== wdata)) begin
            errors++;
            $display("FAIL bus_fields: we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, wr, addr, wdata);
          end
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      exp_stall = (cyc < stall_n);
      checks++;
      if (stall !== exp_stall) begin
        errors++;
        $display("FAIL stall cyc%0d: got %0b, required %0b", cyc, stall, exp_stall);
      end
      exp_pcsrc = !exp_stall && (g_jp || (g_br && g_z));
      checks++;
      if (pcsrc !== exp_pcsrc || flush !== exp_pcsrc || pc_target !== exp_target) begin
        errors++;
        $display("FAIL redirect cyc%0d: pcsrc=%0b flush=%0b tgt=%h, required pcsrc=%0b tgt=%h",
                 cyc, pcsrc, flush, pc_target, exp_pcsrc, exp_target);
      end
      if (cyc > 0 && cyc <= stall_n) begin
        checks++;
        if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0) begin
          errors++;
          $display("FAIL bubble cyc%0d: RegWrite_out=%0b MemtoReg_out=%0b, required 0 0",
                   cyc, RegWrite_out, MemtoReg_out);
        end
      end
      if (bus_err) berr_seen++;
      if (stall) stall_seen++;
      if (!stall) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack = 1'b0;
    last_stall_cycles = stall_seen;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL retire_timeout: stall still %0b after %0d cycles, required retire", stall, cyc);
    end
    if (op && !mis && !tmo) m_rdata = rdata_v;
    checks++;
    if (RegWrite_out !== (rw && !mis && !tmo) || MemtoReg_out !== mtr ||
        regRd_out !== ridx || aluresult_out !== addr || readdata_out !== m_rdata) begin
      errors++;
      $display("FAIL memwb: rw=%0b mtr=%0b rd=%0d alu=%h rdata=%h, required rw=%0b mtr=%0b rd=%0d alu=%h rdata=%h",
               RegWrite_out, MemtoReg_out, regRd_out, aluresult_out, readdata_out,
               rw && !mis && !tmo, mtr, ridx, addr, m_rdata);
    end
    checks++;
    if (req_seen != busy || berr_seen != int'(tmo) || align_err !== mis) begin
      errors++;
      $display("FAIL access_summary: req_cycles=%0d bus_err_cycles=%0d align_err=%0b, required %0d %0d %0b",
               req_seen, berr_seen, align_err, busy, int'(tmo), mis);
    end
    drive_nop();
    @(posedge clk); #1;
    checks++;
    if (align_err !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end: align_err=%0b bus_err=%0b mem_req=%0b, required 0 0 0",
               align_err, bus_err, mem_req);
    end
  endtask

  task automatic clear_redirect();
    g_br = 0; g_jp = 0; g_z = 0; g_bpc = '0; g_jaddr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_nop();
    mem_ack = 1'b0; mem_rdata = '0;
    m_rdata = '0;
    #23;
    checks++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 ||
        bus_err !== 0 || align_err !== 0 || stall !== 0 || RegWrite_out !== 0 ||
        MemtoReg_out !== 0 || regRd_out !== 0 || readdata_out !== 0 || aluresult_out !== 0) begin
      errors++;
      $display("FAIL reset_values: req=%0b we=%0b addr=%h rw=%0b rd=%0d rdata=%h alu=%h, required all 0",
               mem_req, mem_we, mem_addr, RegWrite_out, regRd_out, readdata_out, aluresult_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    clear_redirect();
    run_instr(0, 0, 1, 0, 5'd5, 32'h10, 32'h0, 1, 32'h0);
  endtask

  task automatic test_load();
    clear_redirect();
    run_instr(1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++;
    if (last_stall_cycles != 4) begin
      errors++;
      $display("FAIL load_stall_len: got %0d, required 4", last_stall_cycles);
    end
  endtask

  task automatic test_store();
    clear_redirect();
    run_instr(0, 1, 0, 0, 5'd0, 32'h104, 32'h55, 1, 32'h0);
    checks++;
    if (last_stall_cycles != 2) begin
      errors++;
      $display("FAIL store_stall_len: got %0d, required 2", last_stall_cycles);
    end
  endtask

  task automatic test_misaligned();
    clear_redirect();
    run_instr(1, 0, 1, 1, 5'd9, 32'h102, 32'h0, 1, 32'h0);
  endtask

  task automatic test_timeout();
    clear_redirect();
    run_instr(1, 0, 1, 1, 5'd3, 32'h200, 32'h0, 100, 32'h12345678);
    clear_redirect();
    run_instr(1, 0, 1, 1, 5'd4, 32'h204, 32'h0, TMO, 32'hCAFE0001);
  endtask

  task automatic test_redirect();
    g_br = 1; g_z = 1; g_jp = 1; g_jaddr = 32'h400; g_bpc = 32'h800;
    run_instr(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h0);
    g_br = 1; g_z = 1; g_jp = 0; g_jaddr = 32'h400; g_bpc = 32'h800;
    run_instr(1, 0, 1, 1, 5'd2, 32'h300, 32'h0, 2, 32'h0BADF00D);
  endtask

  task automatic test_reset_busy();
    int guard;
    clear_redirect();
    MemRead_in = 1; memadd_in = 32'h240; RegWrite_in = 1; MemtoReg_in = 1;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || guard >= 10) begin
      errors++;
      $display("FAIL reset_mid_busy: mem_req=%0b guard=%0d, required mem_req 0", mem_req, guard);
    end
    drive_nop();
    m_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || readdata_out !== 32'h0) begin
      errors++;
      $display("FAIL after_reset_busy: mem_req=%0b stall=%0b rdata=%h, required 0 0 0",
               mem_req, stall, readdata_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      g_br = 1'($urandom); g_jp = 1'($urandom); g_z = 1'($urandom);
      g_bpc = $urandom; g_jaddr = $urandom;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom), addr, $urandom, $urandom_range(1, 20), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    clear_redirect();
    run_instr(1, 0, 1, 1, 5'd11, 32'h500, 32'h0, 2, 32'h11112222);
    run_instr(0, 1, 0, 0, 5'd12, 32'h504, 32'hA5A5A5A5, 5, 32'h0);
    run_instr(1, 1, 1, 0, 5'd13, 32'h508, 32'h77, 1, 32'h33334444);
    run_instr(0, 0, 1, 0, 5'd14, 32'h50B, 32'h0, 1, 32'h0);
  endtask

  initial begin
    clear_redirect();
    last_stall_cycles = 0;
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_redirect();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
